// File: rtl/cpu_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, writes instruction
// memory, and holds the CPU in reset until the image is loaded and a settle delay expires.
module cpu_boot_loader #(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned RELEASE_CYCLES = 10
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_reset_o,
   output logic              load_done_o,
   output logic              err_o,
   output logic [15:0]       words_loaded_o
);

   localparam int unsigned CAP   = 32'd1 << ADDR_W;
   localparam int unsigned CNT_W = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_LOAD,
      S_RELEASE_WAIT,
      S_RUN
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_ready;
   logic                w_xfer;
   logic                w_last_word;
   logic                w_in_range;
   logic [15:0]         w_count;
   logic [7:0]          r_count_lo;
   logic [15:0]         r_count;
   logic [1:0]          r_idx;
   logic [23:0]         r_asm;
   logic [CNT_W-1:0]    r_rel_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_cpu_reset;
   logic                r_load_done;
   logic                r_err;
   logic [15:0]         r_words;

   // Byte acceptance is a pure decode of state so the host sees it in the same cycle.
   assign w_ready     = (r_state == S_HDR0 || r_state == S_HDR1 ||
                         r_state == S_LOAD || r_state == S_RUN) && !reset_i;
   assign w_xfer      = byte_valid_i && w_ready;
   assign w_count     = {byte_i, r_count_lo};
   assign w_last_word = (17'(r_words) + 17'd1) == 17'(r_count);
   assign w_in_range  = 32'(r_words) < CAP;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_HDR0;
      else         r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HDR0: if (w_xfer) w_next = S_HDR1;
         S_HDR1: if (w_xfer) w_next = (w_count == 16'd0) ? S_RELEASE_WAIT : S_LOAD;
         S_LOAD: if (w_xfer && r_idx == 2'd3 && w_last_word) w_next = S_RELEASE_WAIT;
         S_RELEASE_WAIT: if (r_rel_cnt == CNT_W'(0)) w_next = S_RUN;
         S_RUN: if (w_xfer) w_next = S_HDR1;
         default: w_next = S_HDR0;
      endcase
   end

   // Header capture, word assembly, memory write and release control
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count_lo  <= 8'd0;
         r_count     <= 16'd0;
         r_idx       <= 2'd0;
         r_asm       <= 24'd0;
         r_rel_cnt   <= CNT_W'(0);
         r_we        <= 1'b0;
         r_addr      <= ADDR_W'(0);
         r_wdata     <= 32'd0;
         r_cpu_reset <= 1'b1;
         r_load_done <= 1'b0;
         r_err       <= 1'b0;
         r_words     <= 16'd0;
      end else begin
         r_we        <= 1'b0;
         r_cpu_reset <= (w_next != S_RUN);
         r_load_done <= (w_next == S_RUN);

         if (r_state != S_RELEASE_WAIT && w_next == S_RELEASE_WAIT)
            r_rel_cnt <= CNT_W'(RELEASE_CYCLES);
         else if (r_state == S_RELEASE_WAIT && r_rel_cnt != CNT_W'(0))
            r_rel_cnt <= r_rel_cnt - CNT_W'(1);

         if (w_xfer) begin
            case (r_state)
               S_HDR0, S_RUN: r_count_lo <= byte_i;
               S_HDR1: begin
                  r_count <= w_count;
                  r_words <= 16'd0;
                  r_err   <= 32'(w_count) > CAP;
                  r_idx   <= 2'd0;
               end
               S_LOAD: begin
                  r_idx <= r_idx + 2'd1;
                  if (r_idx != 2'd3) begin
                     r_asm <= {byte_i, r_asm[23:8]};
                  end else begin
                     // Words past capacity are consumed and counted but never written.
                     r_we    <= w_in_range;
                     r_addr  <= r_words[ADDR_W-1:0];
                     r_wdata <= {byte_i, r_asm};
                     if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign byte_ready_o   = w_ready;
   assign imem_we_o      = r_we;
   assign imem_addr_o    = r_addr;
   assign imem_wdata_o   = r_wdata;
   assign cpu_reset_o    = r_cpu_reset;
   assign load_done_o    = r_load_done;
   assign err_o          = r_err;
   assign words_loaded_o = r_words;

endmodule
